exc_ctrl: RTL

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_pkg.sv | 51 +++++
 rtl/exc_timer.sv | 30 +++
 rtl/exc_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Exception controller shared types: FSM states, cause codes,
// pending-bit indices and cause/priority helpers.
package exc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HANDLER
  } state_t;

  localparam logic [3:0] CAUSE_NONE    = 4'b0000;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'b0001;
  localparam logic [3:0] CAUSE_TIMER   = 4'b0010;
  localparam logic [3:0] CAUSE_IRQ0    = 4'b0011;
  localparam logic [3:0] CAUSE_IRQ1    = 4'b0100;

  localparam int PEND_ILLEGAL = 0;
  localparam int PEND_TIMER   = 1;
  localparam int PEND_IRQ0    = 2;
  localparam int PEND_IRQ1    = 3;

  // Highest-priority pending cause: illegal > timer > irq0 > irq1.
  function automatic logic [3:0] top_cause(input logic [3:0] p);
    logic [3:0] c;
    c = CAUSE_NONE;
    if (p[PEND_ILLEGAL])
      c = CAUSE_ILLEGAL;
    else if (p[PEND_TIMER])
      c = CAUSE_TIMER;
    else if (p[PEND_IRQ0])
      c = CAUSE_IRQ0;
    else if (p[PEND_IRQ1])
      c = CAUSE_IRQ1;
    return c;
  endfunction

  // One-hot pending mask for a cause code.
  function automatic logic [3:0] cause_mask(input logic [3:0] c);
    logic [3:0] m;
    m = 4'b0000;
    case (c)
      CAUSE_ILLEGAL: m[PEND_ILLEGAL] = 1'b1;
      CAUSE_TIMER:   m[PEND_TIMER]   = 1'b1;
      CAUSE_IRQ0:    m[PEND_IRQ0]    = 1'b1;
      CAUSE_IRQ1:    m[PEND_IRQ1]    = 1'b1;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/exc_timer.sv
// Periodic event timer: one tick every timer_period cycles while enabled.
// Ports: clk, reset (async low), timer_en, timer_period, tick.
module exc_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          timer_en,
  input  logic [TW-1:0] timer_period,
  output logic          tick
);

  logic [TW-1:0] cnt;
  logic          run;

  assign run  = timer_en && (timer_period != '0);
  assign tick = run && (cnt == TW'(1));

  // A zero count while running only happens straight after reset,
  // so it is treated as a load rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (!run || tick || cnt == '0)
      cnt <= timer_period;
    else
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: pending/priority logic and IDLE/REQ/HANDLER FSM.
// Ports: clk, reset, ext_irq, illegal_instr, timer_*, ExcAck, ERet -> Exc, EStatus, in_handler, pending, lost_event.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    ext_irq,
  input  logic          illegal_instr,
  input  logic          timer_en,
  input  logic [TW-1:0] timer_period,
  input  logic          ExcAck,
  input  logic          ERet,
  output logic          Exc,
  output logic [3:0]    EStatus,
  output logic          in_handler,
  output logic [3:0]    pending,
  output logic          lost_event
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cause;
  logic [1:0] irq_s1;
  logic [1:0] irq_s2;
  logic [1:0] irq_q;
  logic [1:0] irq_rise;
  logic       tick;
  logic [3:0] ev;
  logic [3:0] clr;

  exc_timer #(.TW(TW)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .timer_en     (timer_en),
    .timer_period (timer_period),
    .tick         (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
      irq_q  <= '0;
    end else begin
      irq_s1 <= ext_irq;
      irq_s2 <= irq_s1;
      irq_q  <= irq_s2;
    end
  end

  assign irq_rise = irq_s2 & ~irq_q;

  always_comb begin
    ev = '0;
    ev[PEND_ILLEGAL] = illegal_instr;
    ev[PEND_TIMER]   = tick;
    ev[PEND_IRQ0]    = irq_rise[0];
    ev[PEND_IRQ1]    = irq_rise[1];
  end

  assign clr = (state == S_REQ && ExcAck) ? cause_mask(cause) : 4'b0000;

  // Set beats clear; a set onto a bit that stays set is a lost event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      lost_event <= 1'b0;
    end else begin
      pending    <= (pending & ~clr) | ev;
      lost_event <= lost_event | (|(ev & pending & ~clr));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (|pending) state_nx = S_REQ;
      S_REQ:     if (ExcAck)   state_nx = S_HANDLER;
      S_HANDLER: if (ERet)     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Cause is captured when leaving IDLE and held until ERet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cause <= CAUSE_NONE;
    else if (state == S_IDLE && |pending)
      cause <= top_cause(pending);
    else if (state == S_HANDLER && ERet)
      cause <= CAUSE_NONE;
  end

  always_comb begin
    Exc        = (state == S_REQ);
    in_handler = (state == S_HANDLER);
    EStatus    = cause;
  end

endmodule
